// File: rtl/uart_tx_mmio_if.sv
// MMIO-side bundle of the UART transmitter: store strobe/data, overflow clear and status readback.
interface uart_tx_mmio_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic             wr_en;
    logic [7:0]       wr_data;
    logic             ovf_clr;
    logic             busy;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             overflow;

    modport master (
        output wr_en, wr_data, ovf_clr,
        input  busy, full, empty, count, overflow
    );

    modport slave (
        input  wr_en, wr_data, ovf_clr,
        output busy, full, empty, count, overflow
    );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: byte FIFO drained LSB-first onto tx, advancing on clk_enable.
module uart_tx_mmio #(
    parameter int ENABLE_FREQ = 50_000_000,
    parameter int BAUD_RATE   = 9600,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clk_enable,
    output logic           tx,
    uart_tx_mmio_if.slave  bus
);
    localparam int BIT_TICKS = ENABLE_FREQ / BAUD_RATE;
    localparam int TICK_W    = (BIT_TICKS < 2) ? 1 : $clog2(BIT_TICKS);
    localparam int PTR_W     = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
    localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BIT_TICKS - 1);
    localparam logic [CNT_W-1:0]  DEPTH_N   = CNT_W'(FIFO_DEPTH);

    generate
        if (BIT_TICKS < 2) begin : gen_bad_baud
            $error("uart_tx_mmio: BIT_TICKS must be at least 2");
        end
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gen_bad_depth
            $error("uart_tx_mmio: FIFO_DEPTH must be a power of two >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_reg,    state_next;
    logic [TICK_W-1:0] tick_reg,     tick_next;
    logic [2:0]        bit_idx_reg,  bit_idx_next;
    logic [7:0]        shift_reg,    shift_next;
    logic              tx_reg,       tx_next;
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic              overflow_reg;
    logic [7:0]        mem [FIFO_DEPTH];

    logic       push;
    logic       drop;
    logic       pop;
    logic       tick_last;
    logic [7:0] head;

    assign push      = bus.wr_en && (count_reg != DEPTH_N);
    assign drop      = bus.wr_en && (count_reg == DEPTH_N);
    assign tick_last = (tick_reg == TICK_LAST);
    // Head is read asynchronously so a byte pushed on one edge can be popped on the next.
    assign head      = mem[rd_ptr_reg];

    always_comb begin
        state_next   = state_reg;
        tick_next    = tick_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        tx_next      = tx_reg;
        pop          = 1'b0;
        unique case (state_reg)
            IDLE: begin
                tick_next = '0;
                tx_next   = 1'b1;
                if (count_reg != '0) begin
                    pop        = 1'b1;
                    shift_next = head;
                    tx_next    = 1'b0;
                    state_next = START;
                end
            end
            START: begin
                if (tick_last) begin
                    tick_next    = '0;
                    tx_next      = shift_reg[0];
                    bit_idx_next = 3'd0;
                    state_next   = DATA;
                end else begin
                    tick_next = tick_reg + 1'b1;
                end
            end
            DATA: begin
                if (tick_last) begin
                    tick_next = '0;
                    if (bit_idx_reg == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        shift_next   = shift_reg >> 1;
                        tx_next      = shift_reg[1];
                        bit_idx_next = bit_idx_reg + 3'd1;
                    end
                end else begin
                    tick_next = tick_reg + 1'b1;
                end
            end
            STOP: begin
                if (tick_last) begin
                    tick_next = '0;
                    if (count_reg != '0) begin
                        pop        = 1'b1;
                        shift_next = head;
                        tx_next    = 1'b0;
                        state_next = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    tick_next = tick_reg + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            tick_reg     <= '0;
            bit_idx_reg  <= 3'd0;
            shift_reg    <= 8'd0;
            tx_reg       <= 1'b1;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else if (clk_enable) begin
            state_reg   <= state_next;
            tick_reg    <= tick_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            tx_reg      <= tx_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)      count_reg <= count_reg + 1'b1;
            else if (pop && !push) count_reg <= count_reg - 1'b1;
            // A drop wins over a coincident clear so no overflow event is lost.
            if (drop)             overflow_reg <= 1'b1;
            else if (bus.ovf_clr) overflow_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && clk_enable && push) begin
            mem[wr_ptr_reg] <= bus.wr_data;
        end
    end

    assign tx           = tx_reg;
    assign bus.busy     = (state_reg != IDLE);
    assign bus.full     = (count_reg == DEPTH_N);
    assign bus.empty    = (count_reg == '0);
    assign bus.count    = count_reg;
    assign bus.overflow = overflow_reg;
endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed bench for uart_tx_mmio with BIT_TICKS=4 and a 4-entry FIFO; checks tx edge by edge.
module tb_uart_tx_mmio;
    logic clk;
    logic rst_n;
    logic clk_enable;
    logic tx;

    int total;
    int passed;

    uart_tx_mmio_if #(.FIFO_DEPTH(4)) bus ();

    uart_tx_mmio #(
        .ENABLE_FREQ(40),
        .BAUD_RATE  (10),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_enable(clk_enable),
        .tx        (tx),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic exp_level(input logic [7:0] b, input int k);
        int bi;
        bi = k / 4;
        if (bi == 0) return 1'b0;
        if (bi == 9) return 1'b1;
        return b[bi-1];
    endfunction

    // Position k of a frame is observed after the (k+1)th enabled edge following the push edge.
    task automatic check_frame(input logic [7:0] b, input int first, input int last_excl);
        for (int k = first; k < last_excl; k++) begin
            check($sformatf("frame %02h pos %0d tx", b, k), 32'(tx), 32'(exp_level(b, k)));
            check($sformatf("frame %02h pos %0d busy", b, k), 32'(bus.busy), 32'd1);
            tick(1);
        end
    endtask

    task automatic push(input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        tick(1);
        bus.wr_en   = 1'b0;
    endtask

    initial begin
        logic bad;
        total          = 0;
        passed         = 0;
        rst_n          = 1'b0;
        clk_enable     = 1'b1;
        bus.wr_en      = 1'b0;
        bus.wr_data    = 8'h00;
        bus.ovf_clr    = 1'b0;

        // Reset and idle line
        @(negedge clk);
        tick(3);
        rst_n = 1'b1;
        check("rst tx", 32'(tx), 32'd1);
        check("rst busy", 32'(bus.busy), 32'd0);
        check("rst empty", 32'(bus.empty), 32'd1);
        check("rst full", 32'(bus.full), 32'd0);
        check("rst count", 32'(bus.count), 32'd0);
        check("rst overflow", 32'(bus.overflow), 32'd0);
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (tx !== 1'b1) bad = 1'b1;
        end
        check("idle tx held high", 32'(bad), 32'd0);

        // Single byte 0xA5
        push(8'hA5);
        check("a5 count after push", 32'(bus.count), 32'd1);
        check("a5 tx before start", 32'(tx), 32'd1);
        check("a5 busy before start", 32'(bus.busy), 32'd0);
        tick(1);
        check("a5 count after pop", 32'(bus.count), 32'd0);
        check_frame(8'hA5, 0, 40);
        check("a5 busy after frame", 32'(bus.busy), 32'd0);
        check("a5 tx after frame", 32'(tx), 32'd1);
        tick(5);

        // Three back-to-back frames
        bus.wr_en = 1'b1; bus.wr_data = 8'h01; tick(1);
        bus.wr_data = 8'h02; tick(1);
        bus.wr_data = 8'h03; tick(1);
        bus.wr_en = 1'b0;
        check("b2b count queued", 32'(bus.count), 32'd2);
        check_frame(8'h01, 1, 40);
        check("b2b count after 2nd pop", 32'(bus.count), 32'd1);
        check_frame(8'h02, 0, 40);
        check("b2b empty after 3rd pop", 32'(bus.empty), 32'd1);
        check_frame(8'h03, 0, 40);
        check("b2b busy after frames", 32'(bus.busy), 32'd0);
        tick(3);

        // Overflow: six writes into a four-entry FIFO
        bus.wr_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.wr_data = 8'h10 + 8'(i);
            tick(1);
        end
        bus.wr_en = 1'b0;
        check("ovf full", 32'(bus.full), 32'd1);
        check("ovf count", 32'(bus.count), 32'd4);
        check("ovf overflow set", 32'(bus.overflow), 32'd1);
        bus.wr_en = 1'b1; bus.wr_data = 8'h16; bus.ovf_clr = 1'b1;
        tick(1);
        bus.wr_en = 1'b0;
        check("ovf drop beats clear", 32'(bus.overflow), 32'd1);
        tick(1);
        bus.ovf_clr = 1'b0;
        check("ovf cleared", 32'(bus.overflow), 32'd0);
        check("ovf still full", 32'(bus.count), 32'd4);
        check_frame(8'h10, 6, 40);
        check_frame(8'h11, 0, 40);
        check_frame(8'h12, 0, 40);
        check_frame(8'h13, 0, 40);
        check_frame(8'h14, 0, 40);
        check("ovf idle after 5 frames", 32'(bus.busy), 32'd0);
        check("ovf empty after 5 frames", 32'(bus.empty), 32'd1);
        tick(3);

        // Stall in the middle of data bit 3; writes during the stall are ignored
        push(8'h3C);
        tick(1);
        check_frame(8'h3C, 0, 18);
        clk_enable  = 1'b0;
        bus.wr_en   = 1'b1;
        bus.wr_data = 8'h55;
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (tx !== 1'b1 || bus.busy !== 1'b1 || bus.count !== 3'd0) bad = 1'b1;
        end
        bus.wr_en  = 1'b0;
        clk_enable = 1'b1;
        check("stall state held", 32'(bad), 32'd0);
        check_frame(8'h3C, 18, 40);
        check("stall busy after frame", 32'(bus.busy), 32'd0);
        check("stall write ignored", 32'(bus.empty), 32'd1);
        tick(3);

        // Reset during data bit 5 with two bytes queued
        bus.wr_en = 1'b1; bus.wr_data = 8'h0F; tick(1);
        bus.wr_data = 8'h77; tick(1);
        bus.wr_data = 8'h99; tick(1);
        bus.wr_en = 1'b0;
        check("mrst count queued", 32'(bus.count), 32'd2);
        check_frame(8'h0F, 1, 26);
        check("mrst tx low before reset", 32'(tx), 32'd0);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        check("mrst tx", 32'(tx), 32'd1);
        check("mrst count", 32'(bus.count), 32'd0);
        check("mrst busy", 32'(bus.busy), 32'd0);
        check("mrst empty", 32'(bus.empty), 32'd1);
        bad = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (tx !== 1'b1 || bus.busy !== 1'b0) bad = 1'b1;
        end
        check("mrst no further frames", 32'(bad), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
